// File: rtl/nlca_stepper_if.sv
// Control/status bundle for the nlca_stepper pattern generator.
// The master side drives seed and control; the slave side returns state and status.
interface nlca_stepper_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) ();
   logic [WIDTH-1:0] seed;
   logic             load;
   logic             step;
   logic             wrap_mode;
   logic [WIDTH-1:0] state;
   logic             match;
   logic [CNT_W-1:0] period;
   logic             fixed;
   logic             sat;

   modport master (
      output seed, load, step, wrap_mode,
      input  state, match, period, fixed, sat
   );

   modport slave (
      input  seed, load, step, wrap_mode,
      output state, match, period, fixed, sat
   );
endinterface

// File: rtl/nlca_stepper.sv
// Clocked nonlinear cellular-automaton stepper with seed-return period measurement.
// Rule: next[i] = s[i] ^ ~(s[i+1] | s[i+2]), with a cyclic or null boundary.
module nlca_stepper #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input logic          clk,
   input logic          reset,
   nlca_stepper_if.slave bus
);

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [WIDTH-1:0] next_state;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             match_q, match_d;
   logic             sat_q, sat_d;

   // Neighbour indices wrap modulo WIDTH; out-of-range neighbours are gated off in null mode.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      localparam int unsigned J1 = (i + 1) % WIDTH;
      localparam int unsigned J2 = (i + 2) % WIDTH;
      localparam bit In1 = (i + 1 < WIDTH);
      localparam bit In2 = (i + 2 < WIDTH);
      logic b1, b2;
      assign b1 = state_q[J1] & (In1 | bus.wrap_mode);
      assign b2 = state_q[J2] & (In2 | bus.wrap_mode);
      assign next_state[i] = state_q[i] ^ ~(b1 | b2);
   end

   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d  = state_q;
      seed_d   = seed_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      sat_d    = sat_q;
      match_d  = 1'b0;
      if (bus.load) begin
         state_d = bus.seed;
         seed_d  = bus.seed;
         cnt_d   = '0;
         sat_d   = 1'b0;
      end else if (bus.step) begin
         state_d = next_state;
         if (next_state == seed_q) begin
            match_d  = 1'b1;
            period_d = cnt_inc;
            cnt_d    = '0;
            sat_d    = 1'b0;
         end else begin
            cnt_d = cnt_inc;
            sat_d = sat_q | (&cnt_inc);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= '0;
         seed_q   <= '0;
         cnt_q    <= '0;
         period_q <= '0;
         match_q  <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         seed_q   <= seed_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         match_q  <= match_d;
         sat_q    <= sat_d;
      end
   end

   assign bus.state  = state_q;
   assign bus.match  = match_q;
   assign bus.period = period_q;
   assign bus.sat    = sat_q;
   assign bus.fixed  = (next_state == state_q);

endmodule

// File: tb/tb_nlca_stepper.sv
// Self-checking bench for nlca_stepper: three instances driven in lockstep,
// compared every cycle against a shift/rotate-based reference model.
module tb_nlca_stepper;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nlca_stepper_if #(.WIDTH(4), .CNT_W(16)) if_a ();
   nlca_stepper_if #(.WIDTH(4), .CNT_W(2))  if_b ();
   nlca_stepper_if #(.WIDTH(8), .CNT_W(16)) if_c ();

   nlca_stepper #(.WIDTH(4), .CNT_W(16)) u_a (.clk(clk), .reset(rst), .bus(if_a));
   nlca_stepper #(.WIDTH(4), .CNT_W(2))  u_b (.clk(clk), .reset(rst), .bus(if_b));
   nlca_stepper #(.WIDTH(8), .CNT_W(16)) u_c (.clk(clk), .reset(rst), .bus(if_c));

   int unsigned n_asserts = 0;
   int unsigned n_fails   = 0;

   int unsigned w_of[3]  = '{4, 4, 8};
   int unsigned cw_of[3] = '{16, 2, 16};
   string       nm[3]    = '{"A", "B", "C"};

   int unsigned m_state[3];
   int unsigned m_seed[3];
   int unsigned m_cnt[3];
   int unsigned m_period[3];
   bit          m_sat[3];
   bit          m_match[3];
   bit          cur_wrap;

   function automatic int unsigned ca_next(input int unsigned s, input int unsigned w,
                                           input bit wrap);
      int unsigned mask, r1, r2;
      mask = (32'd1 << w) - 32'd1;
      if (wrap) begin
         r1 = ((s >> 1) | (s << (w - 1))) & mask;
         r2 = ((s >> 2) | (s << (w - 2))) & mask;
      end else begin
         r1 = s >> 1;
         r2 = s >> 2;
      end
      return (s ^ ~(r1 | r2)) & mask;
   endfunction

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit ld, input bit st, input bit wr,
                             input int unsigned sd);
      for (int d = 0; d < 3; d++) begin
         int unsigned mask, maxc, n, inc;
         mask = (32'd1 << w_of[d]) - 32'd1;
         maxc = (32'd1 << cw_of[d]) - 32'd1;
         if (r) begin
            m_state[d] = 0; m_seed[d] = 0; m_cnt[d] = 0; m_period[d] = 0;
            m_sat[d] = 1'b0; m_match[d] = 1'b0;
         end else if (ld) begin
            m_state[d] = sd & mask; m_seed[d] = sd & mask; m_cnt[d] = 0;
            m_sat[d] = 1'b0; m_match[d] = 1'b0;
         end else if (st) begin
            n   = ca_next(m_state[d], w_of[d], wr);
            inc = (m_cnt[d] >= maxc) ? maxc : m_cnt[d] + 1;
            m_state[d] = n;
            if (n == m_seed[d]) begin
               m_match[d] = 1'b1; m_period[d] = inc; m_cnt[d] = 0; m_sat[d] = 1'b0;
            end else begin
               m_match[d] = 1'b0; m_cnt[d] = inc;
               if (inc == maxc) m_sat[d] = 1'b1;
            end
         end else begin
            m_match[d] = 1'b0;
         end
      end
   endtask

   task automatic check_dut(input int d, input int unsigned st, input bit mt,
                            input int unsigned per, input bit fx, input bit sa);
      bit efx;
      efx = (ca_next(m_state[d], w_of[d], cur_wrap) == m_state[d]);
      chk($sformatf("%s.state", nm[d]), st, m_state[d]);
      chk($sformatf("%s.match", nm[d]), {31'b0, mt}, {31'b0, m_match[d]});
      chk($sformatf("%s.period", nm[d]), per, m_period[d]);
      chk($sformatf("%s.fixed", nm[d]), {31'b0, fx}, {31'b0, efx});
      chk($sformatf("%s.sat", nm[d]), {31'b0, sa}, {31'b0, m_sat[d]});
   endtask

   task automatic cyc(input bit r, input bit ld, input bit st, input bit wr,
                      input int unsigned sd);
      rst = r;
      cur_wrap = wr;
      if_a.load = ld; if_a.step = st; if_a.wrap_mode = wr; if_a.seed = 4'(sd);
      if_b.load = ld; if_b.step = st; if_b.wrap_mode = wr; if_b.seed = 4'(sd);
      if_c.load = ld; if_c.step = st; if_c.wrap_mode = wr; if_c.seed = 8'(sd);
      @(posedge clk);
      model_edge(r, ld, st, wr, sd);
      #1;
      check_dut(0, 32'(if_a.state), if_a.match, 32'(if_a.period), if_a.fixed, if_a.sat);
      check_dut(1, 32'(if_b.state), if_b.match, 32'(if_b.period), if_b.fixed, if_b.sat);
      check_dut(2, 32'(if_c.state), if_c.match, 32'(if_c.period), if_c.fixed, if_c.sat);
   endtask

   initial begin
      bit r, ld, st, wr;
      int unsigned exp_seq[4];
      exp_seq = '{32'h2, 32'h4, 32'h8, 32'h1};

      // reset
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 0);
      chk("rst_state", 32'(if_a.state), 0);
      chk("rst_fixed", {31'b0, if_a.fixed}, 0);

      // cyclic rotation of a single one, period 4
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h1);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h1);
         chk($sformatf("rot_state%0d", k), 32'(if_a.state), exp_seq[k]);
         chk($sformatf("rot_match%0d", k), {31'b0, if_a.match}, (k == 3) ? 1 : 0);
         chk($sformatf("rot_fixed%0d", k), {31'b0, if_a.fixed}, 0);
      end
      chk("rot_period", 32'(if_a.period), 4);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h1);
      chk("rot_match_drop", {31'b0, if_a.match}, 0);

      // all-zero seed reaches the all-ones fixed point; B saturates its 2-bit counter
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
         chk($sformatf("fp_state%0d", k), 32'(if_a.state), 32'hf);
         chk($sformatf("fp_fixed%0d", k), {31'b0, if_a.fixed}, 1);
         chk($sformatf("fp_match%0d", k), {31'b0, if_a.match}, 0);
         chk($sformatf("fp_bsat%0d", k), {31'b0, if_b.sat}, (k >= 2) ? 1 : 0);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      chk("load_clr_sat", {31'b0, if_b.sat}, 0);

      // null boundary
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h1);
      chk("null_state", 32'(if_a.state), 32'he);

      // load wins over step, then reset mid-run
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h1);
      chk("ld_st_state", 32'(if_a.state), 32'h1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h1);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h1);
      chk("mid_rst_state", 32'(if_a.state), 0);
      chk("mid_rst_period", 32'(if_a.period), 0);

      // fixed point equal to the seed matches on every step
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'hf);
      for (int k = 0; k < 2; k++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hf);
         chk($sformatf("fps_match%0d", k), {31'b0, if_a.match}, 1);
         chk($sformatf("fps_period%0d", k), 32'(if_a.period), 1);
      end

      // randomized run
      wr = 1'b1;
      for (int k = 0; k < 600; k++) begin
         r  = ($urandom_range(0, 99) == 0);
         ld = ($urandom_range(0, 9) == 0);
         st = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) wr = ~wr;
         cyc(r, ld, st, wr, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule

// File: doc/nlca_stepper.md
Name: nlca_stepper

Overview:
- Clocked, parametrised successor to the team's combinational XOR/NOR mixing cell.
- Holds a WIDTH-bit state register and advances it one generation per enabled step using the rule next[i] = s[i] XOR NOT(s[i+1] OR s[i+2]).
- Has a selectable boundary mode and a seed register.
- Measures the cycle period: steps from load until the state returns to the seed.
- Sits behind the tile's io wrapper as a pattern/entropy generator.

Parameters:
- WIDTH, 8, number of state cells; legal range 3..32.
- CNT_W, 16, width of the step/period counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- seed  input  WIDTH  value captured on load
- load  input  1  capture seed into state and seed register; clear counter
- step  input  1  advance one generation this cycle
- wrap_mode  input  1  1 = cyclic boundary; 0 = null boundary (cells beyond MSB read 0)
- state  output  WIDTH  current state register
- match  output  1  one-cycle pulse when a step lands on the seed value
- period  output  CNT_W  step count latched at last match
- fixed  output  1  level: next state equals current state
- sat  output  1  sticky: step counter saturated

Behaviour:
- Reset is synchronous, active-high, and has priority over all other inputs. It clears:
  - state, the seed register, the counter and period to 0
  - match and sat to 0
- After reset, fixed reflects the combinational next-state of state = 0.
- Next-state function (combinational), for i in 0..WIDTH-1:
  - n[i] = s[i] ^ ~(s[j1] | s[j2]), where j1 = i+1 and j2 = i+2.
  - wrap_mode=1: indices taken mod WIDTH.
  - wrap_mode=0: an index >= WIDTH reads 0.
- Priority per cycle: reset > load > step > hold.
- Load cycle:
  - state <= seed; seed register <= seed; counter <= 0; sat <= 0; match <= 0.
  - period is unchanged.
  - A step asserted in the same cycle is ignored.
- Step cycle, without load:
  - state <= n.
  - Counter increments by 1, saturating at 2^CNT_W-1; sat <= 1 on reaching all-ones.
  - If n == seed register:
    - match <= 1 on the next edge (registered; visible the cycle after the step edge).
    - period <= counter+1 (saturated value if sat).
    - Counter <= 0; sat <= 0.
- match is 0 on every cycle that is not the registered result of a matching step. Back-to-back matching steps give consecutive pulses.
- fixed = (n == state), combinational from state and wrap_mode. It is valid every cycle.
- A fixed point that equals the seed matches on every step, with period=1.
- Changing wrap_mode mid-run takes effect on the next step. It does not clear the counter.
- Hold (no step, no load): all registers keep their values; match deasserts.
- Latency:
  - state updates on the edge at which step is sampled.
  - match and period are visible in the same cycle as that new state.

Test Plan:
- WIDTH=4, wrap_mode=1, load seed=4'b0001, then 4 steps -> state sequence 0010, 0100, 1000, 0001. After the 4th step: match=1 for one cycle, period=4, fixed=0 throughout.
- WIDTH=4, wrap_mode=1, load 4'b0000, 1 step -> state=1111, fixed=1, match=0. Further steps hold 1111 with match=0 and counter incrementing.
- WIDTH=4, wrap_mode=0, load 4'b0001, 1 step -> state=4'b1110. Compare against the wrap_mode=1 result 0010 to confirm boundary handling.
- WIDTH=4, CNT_W=2, wrap_mode=1, load 4'b0000, 5 steps -> sat=1 after the 3rd step, counter held at 3. A subsequent load clears sat.
- Load and step asserted together with seed=4'b0001 -> state=0001 (step ignored), counter=0. Reset asserted mid-run (after 2 steps) -> next cycle state=0, period=0, match=0, sat=0.
- Load seed=4'b1111 with wrap_mode=1, 2 steps -> match pulses on both steps, period=1 each time.
